// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/ifu_fetch.sv
// Fetch unit: one outstanding imem read, registered word held for decode until IDU_ready.
// Latency: request the cycle after leaving IDLE, word valid the cycle after imem_rvalid; backpressure by holding in HOLD.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  input  logic        IDU_ready,
  output logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         fetch_ready_q, fetch_ready_d;
  logic         fault_q, fault_d;
  logic         flush_fault_q, flush_fault_d;
  logic         misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_ready_d = fetch_ready_q;
    fault_d       = fault_q;
    flush_fault_d = flush_fault_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (fetch_en) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          if (misaligned) fault_d = 1'b1;
          else            pc_d    = redirect_pc;
          // A same-cycle response is the one being abandoned, so nothing is left in flight.
          if (imem_rvalid) begin
            state_d = misaligned ? FAULT : IDLE;
          end else begin
            state_d       = FLUSH;
            flush_fault_d = misaligned;
          end
        end else if (imem_rvalid) begin
          if (imem_err) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            instr_d       = imem_rdata;
            fetch_pc_d    = pc_q;
            fetch_ready_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_ready_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d    = redirect_pc;
            state_d = IDLE;
          end
        end else if (IDU_ready) begin
          fetch_ready_d = 1'b0;
          instr_d       = NOP_INSTR;
          pc_d          = pc_q + PC_STEP;
          state_d       = IDLE;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          if (misaligned) begin
            fault_d       = 1'b1;
            flush_fault_d = 1'b1;
          end else begin
            pc_d          = redirect_pc;
            flush_fault_d = 1'b0;
          end
        end
        if (imem_rvalid) state_d = flush_fault_d ? FAULT : IDLE;
      end
      FAULT: begin
        if (redirect_valid && !misaligned) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d  = (state_d == REQ);
    // Address only moves when a new request starts, keeping it stable under imem_req.
    imem_addr_d = (state_d == REQ) ? pc_d : imem_addr_q;
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= NOP_INSTR;
      fetch_pc_q    <= RESET_PC;
      fetch_ready_q <= 1'b0;
      fault_q       <= 1'b0;
      flush_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_ready_q <= fetch_ready_d;
      fault_q       <= fault_d;
      flush_fault_q <= flush_fault_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign Fetch_ready = fetch_ready_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_fault = fault_q;

  a_rvalid_in_flight : assert property (@(posedge soc_clk) disable iff (reset)
    imem_rvalid |-> (state_q == REQ || state_q == FLUSH));

endmodule
